// File: rtl/arriskv_pkg.sv
// arriskv_pkg: shared types and defaults for the arriskv decode hazard logic.
package arriskv_pkg;

   typedef enum logic {RUN, FLUSH} hazard_state_t;

   localparam int FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/scoreboard.sv
// scoreboard: per-register busy bits with write-first release of a same-cycle writeback.
module scoreboard #(
   parameter int n_regs_p = 32,
   localparam int wd_addr_p = $clog2(n_regs_p)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_set,
   input  logic [wd_addr_p-1:0] i_set_addr,
   input  logic                 i_clr,
   input  logic [wd_addr_p-1:0] i_clr_addr,
   input  logic [wd_addr_p-1:0] i_rs1,
   input  logic [wd_addr_p-1:0] i_rs2,
   input  logic [wd_addr_p-1:0] i_rd,
   output logic                 o_rs1_busy,
   output logic                 o_rs2_busy,
   output logic                 o_rd_busy,
   output logic [n_regs_p-1:0]  o_busy
);

   logic [n_regs_p-1:0] busy_q, busy_d, busy_byp, one;

   assign one      = n_regs_p'(1);
   assign busy_byp = busy_q & ~(i_clr ? one << i_clr_addr : '0);
   // set is applied after the clear so a same-cycle set/clear leaves the bit set
   assign busy_d   = (busy_byp | (i_set ? one << i_set_addr : '0)) & ~one;

   assign o_rs1_busy = busy_byp[i_rs1];
   assign o_rs2_busy = busy_byp[i_rs2];
   assign o_rd_busy  = busy_byp[i_rd];
   assign o_busy     = busy_q;

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage RAW/WAW stall and redirect flush sequencer.
// HAZARD_CTRL_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl
   import arriskv_pkg::*;
#(
   parameter int n_regs_p       = 32,
   parameter int flush_cycles_p = FLUSH_CYCLES_DEF,
   localparam int wd_addr_p     = $clog2(n_regs_p)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_id_valid,
   input  logic [wd_addr_p-1:0] i_id_rs1,
   input  logic [wd_addr_p-1:0] i_id_rs2,
   input  logic                 i_id_rs1_use,
   input  logic                 i_id_rs2_use,
   input  logic [wd_addr_p-1:0] i_id_rdest,
   input  logic                 i_id_rd_we,
   input  logic                 i_wb_valid,
   input  logic [wd_addr_p-1:0] i_wb_rdest,
   input  logic                 i_ex_redirect,
   output logic                 o_id_stall,
   output logic                 o_issue,
   output logic                 o_flush,
   output logic [n_regs_p-1:0]  o_busy
`ifdef HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0]          o_stall_cnt,
   output logic [31:0]          o_flush_cnt
`endif
);

   hazard_state_t state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rs1_busy, rs2_busy, rd_busy, haz;

   scoreboard #(.n_regs_p(n_regs_p)) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_set      (o_issue & i_id_rd_we),
      .i_set_addr (i_id_rdest),
      .i_clr      (i_wb_valid),
      .i_clr_addr (i_wb_rdest),
      .i_rs1      (i_id_rs1),
      .i_rs2      (i_id_rs2),
      .i_rd       (i_id_rdest),
      .o_rs1_busy (rs1_busy),
      .o_rs2_busy (rs2_busy),
      .o_rd_busy  (rd_busy),
      .o_busy     (o_busy)
   );

   assign haz        = (i_id_rs1_use & rs1_busy) | (i_id_rs2_use & rs2_busy) | (i_id_rd_we & rd_busy);
   assign o_flush    = i_ex_redirect | (state_q == FLUSH);
   assign o_id_stall = i_id_valid & haz & ~o_flush;
   assign o_issue    = i_id_valid & ~haz & ~o_flush;

   // a redirect always reloads the count, even mid-flush
   always_comb begin
      state_d = i_ex_redirect ? (flush_cycles_p > 1 ? FLUSH : RUN)
              : (state_q == FLUSH && cnt_q == 4'd1) ? RUN : state_q;
      cnt_d   = i_ex_redirect ? 4'(flush_cycles_p - 1)
              : (state_q == FLUSH) ? cnt_q - 4'd1 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = (o_id_stall && ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
      flush_cnt_d = (i_ex_redirect && ~&flush_cnt_q) ? flush_cnt_q + 32'd1 : flush_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table, reset-mid-flush sequence and randomized model check.
module tb_hazard_ctrl;

   localparam int FC = 2;

   typedef struct {
      bit        v;
      bit [4:0]  rs1;
      bit        u1;
      bit [4:0]  rs2;
      bit        u2;
      bit [4:0]  rd;
      bit        we;
      bit        wbv;
      bit [4:0]  wbrd;
      bit        rdr;
      bit        e_stall;
      bit        e_issue;
      bit        e_flush;
      bit [31:0] e_busy;
   } vec_t;

   logic        clk = 0, rst = 1;
   logic        id_valid = 0, rs1_use = 0, rs2_use = 0, rd_we = 0, wb_valid = 0, ex_redirect = 0;
   logic [4:0]  rs1 = 0, rs2 = 0, rdest = 0, wb_rdest = 0;
   logic        id_stall, issue, flush;
   logic [31:0] busy;
   int          n_cmp = 0, n_bad = 0;
`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   hazard_ctrl #(.n_regs_p(32), .flush_cycles_p(FC)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_id_valid    (id_valid),
      .i_id_rs1      (rs1),
      .i_id_rs2      (rs2),
      .i_id_rs1_use  (rs1_use),
      .i_id_rs2_use  (rs2_use),
      .i_id_rdest    (rdest),
      .i_id_rd_we    (rd_we),
      .i_wb_valid    (wb_valid),
      .i_wb_rdest    (wb_rdest),
      .i_ex_redirect (ex_redirect),
      .o_id_stall    (id_stall),
      .o_issue       (issue),
      .o_flush       (flush),
      .o_busy        (busy)
`ifdef HAZARD_CTRL_PERF_EN
      ,
      .o_stall_cnt   (stall_cnt),
      .o_flush_cnt   (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic apply(vec_t t);
      id_valid = t.v; rs1 = t.rs1; rs1_use = t.u1; rs2 = t.rs2; rs2_use = t.u2;
      rdest = t.rd; rd_we = t.we; wb_valid = t.wbv; wb_rdest = t.wbrd; ex_redirect = t.rdr;
   endtask

   task automatic do_reset();
      apply('{default: 0});
      rst = 1;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
   endtask

   vec_t        tbl[20];
   vec_t        r;
   bit   [31:0] m_busy, eff;
   int          m_left, m_stall, m_flush;
   bit          haz;

   initial begin
      //          v rs1 u1 rs2 u2 rd we wbv wbrd rdr  stall issue flush busy_next
      tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 1, 0, 32'h020};
      tbl[1]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'h020};
      tbl[2]  = '{1, 5, 1, 0, 0, 0, 0, 1, 5, 0,  0, 1, 0, 32'h000};
      tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 32'h000};
      tbl[4]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 32'h000};
      tbl[5]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 0, 32'h080};
      tbl[6]  = '{1, 3, 1, 7, 1, 0, 0, 0, 0, 0,  1, 0, 0, 32'h080};
      tbl[7]  = '{1, 7, 0, 0, 0, 4, 1, 0, 0, 0,  0, 1, 0, 32'h090};
      tbl[8]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 32'h090};
      tbl[9]  = '{1, 7, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h090};
      tbl[10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 32'h090};
      tbl[11] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 32'h090};
      tbl[12] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 32'h090};
      tbl[13] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h090};
      tbl[14] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 32'h090};
      tbl[15] = '{1, 0, 0, 0, 0, 9, 1, 1, 9, 0,  0, 1, 0, 32'h290};
      tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 32'h210};
      tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 32'h210};
      tbl[18] = '{1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  1, 0, 0, 32'h210};
      tbl[19] = '{1, 4, 1, 0, 0, 0, 0, 1, 4, 0,  0, 1, 0, 32'h200};

      do_reset();
      chk("reset_busy", busy, 0);
      chk("reset_flush", {31'd0, flush}, 0);

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i]);
         #4;
         chk($sformatf("tbl%0d_stall", i), {31'd0, id_stall}, {31'd0, tbl[i].e_stall});
         chk($sformatf("tbl%0d_issue", i), {31'd0, issue}, {31'd0, tbl[i].e_issue});
         chk($sformatf("tbl%0d_flush", i), {31'd0, flush}, {31'd0, tbl[i].e_flush});
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      end

      // reset arriving while a flush is in progress
      apply('{v: 1, rd: 5, we: 1, default: 0});
      @(posedge clk); #1;
      chk("pre_rst_busy", busy, 32'h220);
      apply('{rdr: 1, default: 0});
      @(posedge clk); #1;
      apply('{default: 0});
      #4;
      chk("mid_flush", {31'd0, flush}, 1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("rst_flush", {31'd0, flush}, 0);
      chk("rst_busy", busy, 0);
`ifdef HAZARD_CTRL_PERF_EN
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
`endif

      do_reset();
      m_busy = 0; m_left = 0; m_stall = 0; m_flush = 0;
      for (int c = 0; c < 400; c++) begin
         r = '{default: 0};
         r.v    = $urandom_range(0, 3) != 0;
         r.rs1  = 5'($urandom_range(0, 7));
         r.u1   = 1'($urandom_range(0, 1));
         r.rs2  = 5'($urandom_range(0, 7));
         r.u2   = 1'($urandom_range(0, 1));
         r.rd   = 5'($urandom_range(0, 7));
         r.we   = 1'($urandom_range(0, 1));
         r.wbv  = $urandom_range(0, 4) < 2;
         r.wbrd = 5'($urandom_range(0, 7));
         r.rdr  = $urandom_range(0, 11) == 0;
         apply(r);
         eff = m_busy;
         if (r.wbv) eff[r.wbrd] = 0;
         haz = (r.u1 && eff[r.rs1]) || (r.u2 && eff[r.rs2]) || (r.we && eff[r.rd]);
         r.e_flush = r.rdr || m_left > 0;
         r.e_stall = r.v && haz && !r.e_flush;
         r.e_issue = r.v && !haz && !r.e_flush;
         #4;
         chk($sformatf("rnd%0d_stall", c), {31'd0, id_stall}, {31'd0, r.e_stall});
         chk($sformatf("rnd%0d_issue", c), {31'd0, issue}, {31'd0, r.e_issue});
         chk($sformatf("rnd%0d_flush", c), {31'd0, flush}, {31'd0, r.e_flush});
         @(posedge clk); #1;
         if (r.wbv) m_busy[r.wbrd] = 0;
         if (r.e_issue && r.we && r.rd != 0) m_busy[r.rd] = 1;
         m_left  = r.rdr ? FC - 1 : (m_left > 0 ? m_left - 1 : 0);
         m_stall += int'(r.e_stall);
         m_flush += int'(r.rdr);
         chk($sformatf("rnd%0d_busy", c), busy, m_busy);
`ifdef HAZARD_CTRL_PERF_EN
         chk($sformatf("rnd%0d_stall_cnt", c), stall_cnt, m_stall);
         chk($sformatf("rnd%0d_flush_cnt", c), flush_cnt, m_flush);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
